// File: rtl/bit_stream_source.sv
// bit_stream_source
// Transmit end of the pattern-detection path. Words are read from a Block RAM
// read port and serialised MSB-first, one bit per one_second_enable tick. The
// serial bit feeds the single-bit input of the pattern detector. The block also
// reports run/idle state, a sticky underrun flag and a saturating bit count.
//
// Ports
//   clock_100Mhz       in   system clock
//   reset              in   synchronous, active-high
//   one_second_enable  in   bit-rate tick, 1-cycle pulse
//   start              in   1-cycle pulse, starts a stream from word 0
//   abort              in   1-cycle pulse, returns to IDLE next cycle
//   loop_mode          in   1 = wrap to word 0 after the last word
//   rd_en / rd_addr    out  RAM read strobe and address
//   rd_data            in   RAM data, valid 1 cycle after rd_en
//   bit_out            out  serial bit, held between ticks
//   bit_strobe         out  1-cycle pulse when bit_out is updated
//   busy               out  high outside IDLE
//   done               out  1-cycle pulse at end of a non-loop stream
//   underrun           out  sticky, a tick arrived while no bit was ready
//   bits_sent          out  bits emitted since start, saturates at 0xFFFF
//   expected_count     out  detector reference count (optional model)
//   fsm_state          out  current FSM state, for observation
//
// Handshake: the RAM port is a fixed-latency read. rd_en is high for exactly
// one cycle (FETCH) and rd_data is consumed on the following cycle (CAPTURE);
// there is no ready/back-pressure on this port.
//
// Configuration macro BSS_EXPECTED_COUNT_EN: when defined, a reference model
// scores aligned 4-bit groups of emitted bits against PATTERN. When undefined,
// expected_count is tied to 0.

module bit_stream_source #(
  parameter int         WORD_W    = 8,
  parameter int         ADDR_W    = 6,
  parameter int         NUM_WORDS = 16,
  parameter logic [3:0] PATTERN   = 4'b1011
) (
  input  logic              clock_100Mhz,
  input  logic              reset,
  input  logic              one_second_enable,
  input  logic              start,
  input  logic              abort,
  input  logic              loop_mode,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WORD_W-1:0] rd_data,
  output logic              bit_out,
  output logic              bit_strobe,
  output logic              busy,
  output logic              done,
  output logic              underrun,
  output logic [15:0]       bits_sent,
  output logic [7:0]        expected_count,
  output logic [2:0]        fsm_state
);

  localparam int                BIT_W     = $clog2(WORD_W);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_WORDS - 1);
  localparam logic [BIT_W-1:0]  TOP_BIT   = BIT_W'(WORD_W - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    CAPTURE = 3'd2,
    SHIFT   = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t             state, state_n;
  logic [WORD_W-1:0]  shreg;
  logic [BIT_W-1:0]   bit_idx;
  logic [ADDR_W-1:0]  word_idx;
  logic               last_bit;
  logic               last_word;
  logic               shift_tick;

  assign last_bit   = (bit_idx == '0);
  assign last_word  = (word_idx == LAST_WORD);
  assign shift_tick = (state == SHIFT) && one_second_enable;

  // State register
  always_ff @(posedge clock_100Mhz) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_n = state;
    rd_en   = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_n = FETCH;
      end
      FETCH: begin
        rd_en   = 1'b1;
        state_n = CAPTURE;
      end
      CAPTURE: state_n = SHIFT;
      SHIFT: begin
        if (shift_tick && last_bit)
          state_n = (last_word && !loop_mode) ? DONE : FETCH;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // abort overrides everything, including a simultaneous start
    if (abort) state_n = IDLE;
  end

  assign rd_addr   = word_idx;
  assign fsm_state = state;

  // Datapath
  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      shreg      <= '0;
      bit_idx    <= '0;
      word_idx   <= '0;
      bit_out    <= 1'b0;
      bit_strobe <= 1'b0;
      underrun   <= 1'b0;
      bits_sent  <= '0;
    end else begin
      bit_strobe <= 1'b0;
      if (abort) begin
        // bits_sent and underrun are left for inspection until next start
        bit_out <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              word_idx  <= '0;
              bits_sent <= '0;
              underrun  <= 1'b0;
            end
          end
          FETCH: begin
            if (one_second_enable) underrun <= 1'b1;
          end
          CAPTURE: begin
            shreg   <= rd_data;
            bit_idx <= TOP_BIT;
            if (one_second_enable) underrun <= 1'b1;
          end
          SHIFT: begin
            if (one_second_enable) begin
              bit_out    <= shreg[WORD_W-1];
              shreg      <= shreg << 1;
              bit_strobe <= 1'b1;
              if (bits_sent != 16'hFFFF) bits_sent <= bits_sent + 16'd1;
              if (last_bit) begin
                if (!last_word)    word_idx <= word_idx + ADDR_W'(1);
                else if (loop_mode) word_idx <= '0;
              end else begin
                bit_idx <= bit_idx - BIT_W'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef BSS_EXPECTED_COUNT_EN
  // Detector reference: aligned, non-overlapping 4-bit groups from start.
  // grp_bits holds the first three bits of the current group.
  logic [2:0] grp_bits;
  logic [1:0] grp_cnt;

  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      grp_bits       <= '0;
      grp_cnt        <= '0;
      expected_count <= '0;
    end else if (abort || state == DONE) begin
      // a partial group at the end of a stream is discarded
      grp_bits <= '0;
      grp_cnt  <= '0;
    end else if (state == IDLE && start) begin
      grp_bits       <= '0;
      grp_cnt        <= '0;
      expected_count <= '0;
    end else if (shift_tick) begin
      grp_bits <= {grp_bits[1:0], shreg[WORD_W-1]};
      grp_cnt  <= grp_cnt + 2'd1;
      if (grp_cnt == 2'd3 && {grp_bits, shreg[WORD_W-1]} == PATTERN)
        expected_count <= expected_count + 8'd1;
    end
  end
`else
  assign expected_count = '0;
`endif

endmodule

// File: tb/tb_bit_stream_source.sv
module tb_bit_stream_source;

  localparam int WORD_W    = 8;
  localparam int ADDR_W    = 6;
  localparam int NUM_WORDS = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              ose = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              loop_mode = 1'b0;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [WORD_W-1:0] rd_data = '0;
  logic              bit_out, bit_strobe, busy, done, underrun;
  logic [15:0]       bits_sent;
  logic [7:0]        expected_count;
  logic [2:0]        fsm_state;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  logic [0:0]        exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];

  logic [WORD_W-1:0] ram [0:63];
  int m_word, m_bit;

  bit_stream_source #(
    .WORD_W(WORD_W), .ADDR_W(ADDR_W), .NUM_WORDS(NUM_WORDS), .PATTERN(4'b1011)
  ) dut (
    .clock_100Mhz(clk), .reset(reset), .one_second_enable(ose),
    .start(start), .abort(abort), .loop_mode(loop_mode),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .bit_out(bit_out), .bit_strobe(bit_strobe), .busy(busy), .done(done),
    .underrun(underrun), .bits_sent(bits_sent),
    .expected_count(expected_count), .fsm_state(fsm_state)
  );

  // ---------------- clock / RAM model ----------------
  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (bit_strobe) begin
        if (exp_q.size() == 0) check("unexpected_strobe", 32'd1, 32'd0);
        else check("sb_bit_out", {31'd0, bit_out}, {31'd0, exp_q.pop_front()});
      end
      if (rd_en) begin
        if (exp_addr_q.size() == 0) check("unexpected_rd_en", 32'd1, 32'd0);
        else check("sb_rd_addr", 32'(rd_addr), 32'(exp_addr_q.pop_front()));
      end
      if (done) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input bit expect_accept);
    if (expect_accept) begin
      m_word = 0;
      m_bit  = 0;
      exp_addr_q.push_back('0);
    end
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic pulse_abort();
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 0;
  endtask

  // One tick after 'gap' idle cycles. When emit is set the bench model
  // predicts the bit (and the next fetch address at word boundaries).
  task automatic drive_tick(input int gap, input bit emit);
    logic [WORD_W-1:0] w;
    repeat (gap) @(posedge clk);
    #1 ose = 1'b1;
    if (emit) begin
      w = ram[m_word];
      exp_q.push_back(w[WORD_W-1-m_bit]);
      m_bit++;
      if (m_bit == WORD_W) begin
        m_bit = 0;
        if (m_word == NUM_WORDS - 1) begin
          if (loop_mode) begin
            m_word = 0;
            exp_addr_q.push_back('0);
          end
        end else begin
          m_word++;
          exp_addr_q.push_back(ADDR_W'(m_word));
        end
      end
    end
    @(posedge clk); #1 ose = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        exp_bit;
    logic [15:0] exp_sent;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t tab [16];

  initial begin
    logic [15:0] stream;
    logic [7:0]  cnt_tab [16];
    int d0;
    stream = 16'b1011_0101_1011_1011;
`ifdef BSS_EXPECTED_COUNT_EN
    cnt_tab = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1,
                8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd2, 8'd3};
`else
    cnt_tab = '{default: 8'd0};
`endif
    for (int i = 0; i < 16; i++) begin
      tab[i].exp_bit  = stream[15-i];
      tab[i].exp_sent = 16'(i + 1);
      tab[i].exp_cnt  = cnt_tab[i];
    end
    for (int i = 0; i < 64; i++) ram[i] = '0;
    ram[0] = 8'hB5;
    ram[1] = 8'hBB;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_bit_out", 32'(bit_out), 0);
    check("rst_bits_sent", 32'(bits_sent), 0);
    check("rst_rd_en", 32'(rd_en), 0);
    check("rst_state", 32'(fsm_state), 0);
    #1 reset = 1'b0;

    // ---- test 1: two-word stream, table driven ----
    pulse_start(1);
    for (int i = 0; i < 16; i++) begin
      drive_tick(3, 1);
      @(negedge clk);
      check("t1_bit_out", 32'(bit_out), 32'(tab[i].exp_bit));
      check("t1_bits_sent", 32'(bits_sent), 32'(tab[i].exp_sent));
      check("t1_expected_count", 32'(expected_count), 32'(tab[i].exp_cnt));
    end
    repeat (3) @(negedge clk);
    check("t1_done_count", done_cnt, 1);
    check("t1_busy", 32'(busy), 0);
    check("t1_bit_out_hold", 32'(bit_out), 1);
    check("t1_underrun", 32'(underrun), 0);
    check("t1_addr_q_empty", exp_addr_q.size(), 0);

    // ---- test 2: tick dropped during refetch ----
    pulse_start(1);
    for (int i = 0; i < 8; i++) drive_tick(3, 1);
    drive_tick(0, 0);
    @(negedge clk);
    check("t2_underrun", 32'(underrun), 1);
    check("t2_bit_out_unchanged", 32'(bit_out), 1);
    check("t2_bits_sent_drop", 32'(bits_sent), 8);
    drive_tick(3, 1);
    @(negedge clk);
    check("t2_bits_sent", 32'(bits_sent), 9);
    pulse_abort();
    @(negedge clk);
    check("t2_underrun_held", 32'(underrun), 1);
    check("t2_busy", 32'(busy), 0);

    // ---- test 3: loop mode, 40 ticks ----
    d0 = done_cnt;
    loop_mode = 1'b1;
    pulse_start(1);
    @(negedge clk);
    check("t3_underrun_cleared", 32'(underrun), 0);
    for (int i = 0; i < 40; i++) drive_tick(3, 1);
    repeat (4) @(negedge clk);
    check("t3_bits_sent", 32'(bits_sent), 40);
    check("t3_no_done", done_cnt, d0);
    check("t3_busy", 32'(busy), 1);
    check("t3_bit_out", 32'(bit_out), 1);
    check("t3_addr_q_empty", exp_addr_q.size(), 0);
    pulse_abort();
    @(negedge clk);
    check("t3_abort_busy", 32'(busy), 0);
    check("t3_abort_bit_out", 32'(bit_out), 0);
    check("t3_abort_sent", 32'(bits_sent), 40);
    loop_mode = 1'b0;

    // ---- test 4: abort after 5 ticks ----
    pulse_start(1);
    for (int i = 0; i < 5; i++) drive_tick(3, 1);
    pulse_abort();
    @(negedge clk);
    check("t4_busy", 32'(busy), 0);
    check("t4_state", 32'(fsm_state), 0);
    check("t4_bit_out", 32'(bit_out), 0);
    check("t4_bits_sent", 32'(bits_sent), 5);
    repeat (3) @(negedge clk);
    check("t4_no_done", done_cnt, d0);

    // ---- test 5: start while busy, then reset mid-stream ----
    pulse_start(1);
    for (int i = 0; i < 3; i++) drive_tick(3, 1);
    @(negedge clk);
    check("t5_bit_out", 32'(bit_out), 1);
    pulse_start(0);
    drive_tick(3, 1);
    @(negedge clk);
    check("t5_bits_sent", 32'(bits_sent), 4);
    check("t5_busy", 32'(busy), 1);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_bit_out", 32'(bit_out), 0);
    check("t5_rst_bits_sent", 32'(bits_sent), 0);
    check("t5_rst_expected_count", 32'(expected_count), 0);
    check("t5_rst_rd_addr", 32'(rd_addr), 0);
    #1 reset = 1'b0;

    // ---- test 6: abort and start together ----
    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("t6_abort_wins", 32'(busy), 0);

    repeat (4) @(negedge clk);
    check("final_bit_q_empty", exp_q.size(), 0);
    check("final_addr_q_empty", exp_addr_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
